// File: rtl/pixel_blk_feeder.sv
// rtl/pixel_blk_feeder.sv - ping-pong 64-pixel block packer feeding the forward DCT
// Optional LEVEL_SHIFT_EN: samples leave as pixel^8'h80 (applied as pixels are stored).
module pixel_blk_feeder #(
  parameter logic [7:0] PAD_VALUE = 8'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       dct_flag,
  input  logic [7:0] pix_data,
  input  logic       pix_data_en,
  input  logic       pix_last,
  output logic       pix_ready,
  input  logic       dct_ready,
  output logic [7:0] dct_data,
  output logic       dct_data_en,
  output logic [5:0] dct_data_idx,
  output logic       dct_last_blk,
  output logic       compress_feed_done,
  output logic       overflow_err
);

  localparam logic [5:0] LAST_IDX = 6'd63;
`ifdef LEVEL_SHIFT_EN
  localparam logic [7:0] SHIFT = 8'h80;
`else
  localparam logic [7:0] SHIFT = 8'h00;
`endif

  typedef enum logic {W_FILL, W_PAD} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DONE} rstate_t;

  logic [7:0] mem [0:127];
  wstate_t    w_state, w_next;
  rstate_t    r_state, r_next;
  logic       wr_bank, wr_bank_nxt, rd_bank;
  logic [5:0] wr_cnt, wr_cnt_nxt, rd_cnt;
  logic [1:0] bank_full, bank_last, full_nxt, last_nxt;
  logic       accept, we, set_full, set_last, clr_full;
  logic [7:0] wdata;
  logic       pix_ready_d, overflow_d, rd_active;

  assign accept = pix_data_en & pix_ready;

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state   <= W_FILL;
      r_state   <= R_IDLE;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= 6'd0;
      rd_cnt    <= 6'd0;
      bank_full <= 2'b00;
      bank_last <= 2'b00;
    end else begin
      w_state   <= w_next;
      r_state   <= r_next;
      wr_bank   <= wr_bank_nxt;
      wr_cnt    <= wr_cnt_nxt;
      bank_full <= full_nxt;
      bank_last <= last_nxt;
      rd_cnt    <= (r_state == R_READ) ? rd_cnt + 6'd1 : 6'd0;
      if (r_state == R_DONE) rd_bank <= ~rd_bank;
    end
  end

  // Next-state logic for both sides
  always_comb begin
    w_next      = w_state;
    wr_bank_nxt = wr_bank;
    wr_cnt_nxt  = wr_cnt;
    we          = 1'b0;
    wdata       = pix_data ^ SHIFT;
    set_full    = 1'b0;
    set_last    = 1'b0;
    case (w_state)
      W_FILL: if (accept) begin
        we         = 1'b1;
        wr_cnt_nxt = wr_cnt + 6'd1;
        if (wr_cnt == LAST_IDX) begin
          set_full    = 1'b1;
          set_last    = pix_last;
          wr_bank_nxt = ~wr_bank;
        end else if (pix_last) begin
          w_next = W_PAD;
        end
      end
      default: begin
        we         = 1'b1;
        wdata      = PAD_VALUE ^ SHIFT;
        wr_cnt_nxt = wr_cnt + 6'd1;
        if (wr_cnt == LAST_IDX) begin
          set_full    = 1'b1;
          set_last    = 1'b1;
          wr_bank_nxt = ~wr_bank;
          w_next      = W_FILL;
        end
      end
    endcase

    r_next   = r_state;
    clr_full = 1'b0;
    case (r_state)
      R_IDLE:  if (bank_full[rd_bank] & dct_ready & dct_flag) r_next = R_READ;
      R_READ:  if (rd_cnt == LAST_IDX) begin
        r_next   = R_DONE;
        clr_full = 1'b1;
      end
      default: r_next = R_IDLE;
    endcase

    // Writer and reader always touch different banks, so both updates land.
    full_nxt = bank_full;
    last_nxt = bank_last;
    if (clr_full) begin
      full_nxt[rd_bank] = 1'b0;
      last_nxt[rd_bank] = 1'b0;
    end
    if (set_full) begin
      full_nxt[wr_bank] = 1'b1;
      last_nxt[wr_bank] = set_last;
    end
  end

  // Output decode; readiness looks ahead so a full bank is never offered
  always_comb begin
    rd_active   = (r_state == R_READ);
    pix_ready_d = dct_flag & ~full_nxt[wr_bank_nxt] & (w_next == W_FILL);
    overflow_d  = pix_data_en & ~pix_ready & dct_flag;
  end

  always_ff @(posedge clock) begin
    if (we) mem[{wr_bank, wr_cnt}] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_ready          <= 1'b0;
      overflow_err       <= 1'b0;
      dct_data           <= 8'd0;
      dct_data_en        <= 1'b0;
      dct_data_idx       <= 6'd0;
      dct_last_blk       <= 1'b0;
      compress_feed_done <= 1'b0;
    end else begin
      pix_ready          <= pix_ready_d;
      overflow_err       <= overflow_err | overflow_d;
      if (rd_active) dct_data <= mem[{rd_bank, rd_cnt}];
      dct_data_en        <= rd_active;
      dct_data_idx       <= rd_active ? rd_cnt : 6'd0;
      dct_last_blk       <= rd_active & bank_last[rd_bank];
      compress_feed_done <= (r_state == R_DONE) & dct_last_blk;
    end
  end

endmodule
